// File: rtl/wb_write_queue.sv
// wb_write_queue
//   In-order write-back buffer in front of the 32x32 register file.
//   Accepts up to two results per cycle (MEM older, then ALU), retires one
//   write per cycle to the register file, and forwards pending results to the
//   decode read ports. A drain FSM lets the context-switch controller wait
//   until every pending write has landed.
//
// Ports
//   CLK, RESET                         clock, synchronous active-high reset
//   MEM_VALID/ADDR/DATA                memory-stage result (enqueued first)
//   ALU_VALID/ADDR/DATA                ALU-stage result (enqueued second)
//   STALL                              upstream must hold off new results
//   RF_WRITE/RF_INADDRESS/RF_IN        register file write port (head entry)
//   LOOKUP1_ADDR, LOOKUP2_ADDR         decode read addresses
//   HIT1/HIT_DATA1, HIT2/HIT_DATA2     youngest pending match per lookup
//   DRAIN_REQ, DRAIN_DONE              drain request level / done pulse
//   COUNT                              current occupancy
//   OVERFLOW                           sticky lost-push flag
module wb_write_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MEM_VALID,
  input  logic [ADDR_WIDTH-1:0]   MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]   MEM_DATA,
  input  logic                    ALU_VALID,
  input  logic [ADDR_WIDTH-1:0]   ALU_ADDR,
  input  logic [DATA_WIDTH-1:0]   ALU_DATA,
  output logic                    STALL,
  output logic                    RF_WRITE,
  output logic [ADDR_WIDTH-1:0]   RF_INADDRESS,
  output logic [DATA_WIDTH-1:0]   RF_IN,
  input  logic [ADDR_WIDTH-1:0]   LOOKUP1_ADDR,
  input  logic [ADDR_WIDTH-1:0]   LOOKUP2_ADDR,
  output logic                    HIT1,
  output logic                    HIT2,
  output logic [DATA_WIDTH-1:0]   HIT_DATA1,
  output logic [DATA_WIDTH-1:0]   HIT_DATA2,
  input  logic                    DRAIN_REQ,
  output logic                    DRAIN_DONE,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    OVERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAINING = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_WAIT     = 2'd3;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic                  overflow_q, overflow_d;

  logic                  idle;
  logic                  mem_req, alu_req;
  logic                  mem_acc, alu_acc;
  logic                  pop;
  logic [CW-1:0]         free_slots;
  logic [PW-1:0]         alu_slot;

  // Push acceptance. Free space is judged on the registered occupancy only,
  // so a same-cycle pop never creates room for an extra push. Address 0
  // results are discarded silently and never take a slot.
  always_comb begin
    idle       = (state_q == ST_IDLE);
    mem_req    = MEM_VALID && (MEM_ADDR != '0);
    alu_req    = ALU_VALID && (ALU_ADDR != '0);
    free_slots = CW'(DEPTH) - count_q;
    mem_acc    = idle && mem_req && (free_slots != '0);
    alu_acc    = idle && alu_req && (free_slots > (mem_acc ? CW'(1) : CW'(0)));
    pop        = (count_q != '0);
  end

  // Queue storage and pointer/occupancy update
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    alu_slot = wr_ptr_q + PW'(mem_acc);
    if (mem_acc) begin
      addr_d[wr_ptr_q] = MEM_ADDR;
      data_d[wr_ptr_q] = MEM_DATA;
    end
    if (alu_acc) begin
      addr_d[alu_slot] = ALU_ADDR;
      data_d[alu_slot] = ALU_DATA;
    end
    wr_ptr_d   = wr_ptr_q + PW'(mem_acc) + PW'(alu_acc);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    overflow_d = overflow_q | (mem_req & ~mem_acc) | (alu_req & ~alu_acc);
  end

  // Drain FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (DRAIN_REQ)        state_d = ST_DRAINING;
      ST_DRAINING: if (count_q == '0)    state_d = ST_DONE;
      ST_DONE:                           state_d = ST_WAIT;
      ST_WAIT:     if (!DRAIN_REQ)       state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Registered state boundary
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry payloads carry no reset; every reader is qualified by occupancy.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Forwarding: scan oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [PW-1:0] slot;
    slot      = rd_ptr_q;
    HIT1      = 1'b0;
    HIT2      = 1'b0;
    HIT_DATA1 = '0;
    HIT_DATA2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((LOOKUP1_ADDR != '0) && (addr_q[slot] == LOOKUP1_ADDR)) begin
          HIT1      = 1'b1;
          HIT_DATA1 = data_q[slot];
        end
        if ((LOOKUP2_ADDR != '0) && (addr_q[slot] == LOOKUP2_ADDR)) begin
          HIT2      = 1'b1;
          HIT_DATA2 = data_q[slot];
        end
      end
    end
  end

  // Output drive from registered state
  always_comb begin
    STALL        = (free_slots < CW'(2)) || !idle;
    RF_WRITE     = pop;
    RF_INADDRESS = pop ? addr_q[rd_ptr_q] : '0;
    RF_IN        = pop ? data_q[rd_ptr_q] : '0;
    DRAIN_DONE   = (state_q == ST_DONE);
    COUNT        = count_q;
    OVERFLOW     = overflow_q;
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue
//   Directed bench for wb_write_queue. Models the register file write port
//   (negedge capture) and keeps a log of retired write data.
module tb_wb_write_queue;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MEM_VALID = 1'b0;
  logic [4:0]  MEM_ADDR = '0;
  logic [31:0] MEM_DATA = '0;
  logic        ALU_VALID = 1'b0;
  logic [4:0]  ALU_ADDR = '0;
  logic [31:0] ALU_DATA = '0;
  logic        STALL;
  logic        RF_WRITE;
  logic [4:0]  RF_INADDRESS;
  logic [31:0] RF_IN;
  logic [4:0]  LOOKUP1_ADDR = '0;
  logic [4:0]  LOOKUP2_ADDR = '0;
  logic        HIT1, HIT2;
  logic [31:0] HIT_DATA1, HIT_DATA2;
  logic        DRAIN_REQ = 1'b0;
  logic        DRAIN_DONE;
  logic [2:0]  COUNT;
  logic        OVERFLOW;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf   [32] = '{default: 32'h0};
  logic [31:0] wlog [64] = '{default: 32'h0};
  int          wcnt = 0;

  wb_write_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
    .STALL(STALL), .RF_WRITE(RF_WRITE), .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN),
    .LOOKUP1_ADDR(LOOKUP1_ADDR), .LOOKUP2_ADDR(LOOKUP2_ADDR),
    .HIT1(HIT1), .HIT2(HIT2), .HIT_DATA1(HIT_DATA1), .HIT_DATA2(HIT_DATA2),
    .DRAIN_REQ(DRAIN_REQ), .DRAIN_DONE(DRAIN_DONE),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Register file model: captures on the negedge inside the cycle.
  always @(negedge CLK) begin
    if (RF_WRITE === 1'b1) begin
      rf[RF_INADDRESS] <= RF_IN;
      wlog[wcnt]       <= RF_IN;
      wcnt             <= wcnt + 1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad);
    MEM_VALID = mv; MEM_ADDR = ma; MEM_DATA = md;
    ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
  endtask

  initial begin
    // Reset
    step(); step();
    check("rst_count",    32'(COUNT), 32'd0);
    check("rst_stall",    32'(STALL), 32'd0);
    check("rst_rfwrite",  32'(RF_WRITE), 32'd0);
    check("rst_rfaddr",   32'(RF_INADDRESS), 32'd0);
    check("rst_rfin",     RF_IN, 32'd0);
    check("rst_hit1",     32'(HIT1), 32'd0);
    check("rst_hitdata1", HIT_DATA1, 32'd0);
    check("rst_done",     32'(DRAIN_DONE), 32'd0);
    check("rst_ovf",      32'(OVERFLOW), 32'd0);
    RESET = 1'b0;

    // Single push
    push(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    step();
    push(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    LOOKUP1_ADDR = 5'd5;
    #1;
    check("single_count",  32'(COUNT), 32'd1);
    check("single_write",  32'(RF_WRITE), 32'd1);
    check("single_addr",   32'(RF_INADDRESS), 32'd5);
    check("single_data",   RF_IN, 32'hDEADBEEF);
    check("single_hit",    32'(HIT1), 32'd1);
    check("single_hitd",   HIT_DATA1, 32'hDEADBEEF);
    check("single_stall",  32'(STALL), 32'd0);
    step();
    check("single_count2", 32'(COUNT), 32'd0);
    check("single_write2", 32'(RF_WRITE), 32'd0);
    check("single_nohit",  32'(HIT1), 32'd0);
    check("single_rf5",    rf[5], 32'hDEADBEEF);

    // Dual push to the same register
    push(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    step();
    push(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    LOOKUP1_ADDR = 5'd7;
    #1;
    check("dual_count",  32'(COUNT), 32'd2);
    check("dual_hit",    32'(HIT1), 32'd1);
    check("dual_hitd",   HIT_DATA1, 32'h22);
    check("dual_head_a", 32'(RF_INADDRESS), 32'd7);
    check("dual_head_d", RF_IN, 32'h11);
    step();
    check("dual_count1", 32'(COUNT), 32'd1);
    check("dual_head2",  RF_IN, 32'h22);
    check("dual_hitd2",  HIT_DATA1, 32'h22);
    step();
    check("dual_count0", 32'(COUNT), 32'd0);
    check("dual_nohit",  32'(HIT1), 32'd0);
    check("dual_nohitd", HIT_DATA1, 32'h0);
    check("dual_rf7",    rf[7], 32'h22);
    check("dual_order0", wlog[wcnt-2], 32'h11);
    check("dual_order1", wlog[wcnt-1], 32'h22);

    // x0 filter
    push(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    push(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    LOOKUP1_ADDR = 5'd0;
    #1;
    check("x0_count", 32'(COUNT), 32'd0);
    check("x0_write", 32'(RF_WRITE), 32'd0);
    check("x0_hit",   32'(HIT1), 32'd0);
    check("x0_ovf",   32'(OVERFLOW), 32'd0);

    // Fill, overflow and pointer wrap
    push(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    step();
    check("fill_count2", 32'(COUNT), 32'd2);
    check("fill_stall2", 32'(STALL), 32'd0);
    check("fill_head1",  RF_IN, 32'hA1);
    push(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
    step();
    check("fill_count3", 32'(COUNT), 32'd3);
    check("fill_stall3", 32'(STALL), 32'd1);
    check("fill_ovf0",   32'(OVERFLOW), 32'd0);
    check("fill_head2",  RF_IN, 32'hA2);
    push(1'b1, 5'd8, 32'hA5, 1'b1, 5'd9, 32'hA6);
    step();
    push(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    LOOKUP1_ADDR = 5'd9;
    LOOKUP2_ADDR = 5'd8;
    #1;
    check("ovf_count",   32'(COUNT), 32'd3);
    check("ovf_flag",    32'(OVERFLOW), 32'd1);
    check("ovf_head3",   RF_IN, 32'hA3);
    check("ovf_alu_hit", 32'(HIT1), 32'd0);
    check("ovf_mem_hit", 32'(HIT2), 32'd1);
    check("ovf_mem_hd",  HIT_DATA2, 32'hA5);
    push(1'b1, 5'd10, 32'hA7, 1'b0, 5'd0, 32'h0);
    step();
    push(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    LOOKUP1_ADDR = 5'd0;
    LOOKUP2_ADDR = 5'd0;
    check("wrap_count",  32'(COUNT), 32'd3);
    check("wrap_head4",  RF_IN, 32'hA4);
    step();
    check("wrap_head5",  RF_IN, 32'hA5);
    check("wrap_addr5",  32'(RF_INADDRESS), 32'd8);
    step();
    check("wrap_head7",  RF_IN, 32'hA7);
    check("wrap_count1", 32'(COUNT), 32'd1);
    step();
    check("wrap_empty",  32'(COUNT), 32'd0);
    check("wrap_stall",  32'(STALL), 32'd0);
    check("wrap_rf9",    rf[9], 32'h0);
    check("wrap_rf10",   rf[10], 32'hA7);
    check("ovf_sticky",  32'(OVERFLOW), 32'd1);

    // Drain on an empty queue, request released while draining
    DRAIN_REQ = 1'b1;
    step();
    DRAIN_REQ = 1'b0;
    check("edrain_stall", 32'(STALL), 32'd1);
    check("edrain_done0", 32'(DRAIN_DONE), 32'd0);
    step();
    check("edrain_done1", 32'(DRAIN_DONE), 32'd1);
    step();
    check("edrain_done2", 32'(DRAIN_DONE), 32'd0);
    check("edrain_wstal", 32'(STALL), 32'd1);
    step();
    check("edrain_idle",  32'(STALL), 32'd0);

    // Drain with three entries queued
    push(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hB2);
    step();
    push(1'b1, 5'd13, 32'hB3, 1'b1, 5'd14, 32'hB4);
    step();
    push(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("drain_cnt3",  32'(COUNT), 32'd3);
    DRAIN_REQ = 1'b1;
    step();
    check("drain_cnt2",  32'(COUNT), 32'd2);
    check("drain_stall", 32'(STALL), 32'd1);
    check("drain_d0",    32'(DRAIN_DONE), 32'd0);
    push(1'b1, 5'd15, 32'hC1, 1'b0, 5'd0, 32'h0);
    step();
    push(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("drain_drop",  32'(COUNT), 32'd1);
    step();
    check("drain_cnt0",  32'(COUNT), 32'd0);
    check("drain_d1",    32'(DRAIN_DONE), 32'd0);
    step();
    check("drain_pulse", 32'(DRAIN_DONE), 32'd1);
    check("drain_stl2",  32'(STALL), 32'd1);
    step();
    check("drain_d3",    32'(DRAIN_DONE), 32'd0);
    check("drain_hold",  32'(STALL), 32'd1);
    step();
    check("drain_hold2", 32'(STALL), 32'd1);
    DRAIN_REQ = 1'b0;
    step();
    check("drain_rel",   32'(STALL), 32'd0);
    check("drain_rf14",  rf[14], 32'hB4);
    check("drain_rf15",  rf[15], 32'h0);

    // Reset in the middle of a drain
    push(1'b1, 5'd16, 32'hD1, 1'b1, 5'd17, 32'hD2);
    step();
    push(1'b1, 5'd18, 32'hD3, 1'b0, 5'd0, 32'h0);
    DRAIN_REQ = 1'b1;
    step();
    push(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("rmid_cnt2",  32'(COUNT), 32'd2);
    check("rmid_stall", 32'(STALL), 32'd1);
    RESET = 1'b1;
    DRAIN_REQ = 1'b0;
    step();
    LOOKUP1_ADDR = 5'd17;
    #1;
    check("rmid_count", 32'(COUNT), 32'd0);
    check("rmid_write", 32'(RF_WRITE), 32'd0);
    check("rmid_rfin",  RF_IN, 32'h0);
    check("rmid_stl0",  32'(STALL), 32'd0);
    check("rmid_done",  32'(DRAIN_DONE), 32'd0);
    check("rmid_ovf",   32'(OVERFLOW), 32'd0);
    check("rmid_hit",   32'(HIT1), 32'd0);
    RESET = 1'b0;
    step();
    check("rmid_done1", 32'(DRAIN_DONE), 32'd0);
    step();
    check("rmid_done2", 32'(DRAIN_DONE), 32'd0);
    check("rmid_wr2",   32'(RF_WRITE), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
